// File: rtl/feature_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : feature_uart_tx
// Brief    : Buffers valid-only feature bytes in a FIFO and sends them as UART 8N1.
// Revision : 1.0 - initial release
// ============================================================================
module feature_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  generate
    if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("feature_uart_tx: illegal CLKS_PER_BIT or FIFO_DEPTH");
    end
  endgenerate

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic          push;
  logic          pop;
  logic          full;
  logic          baud_done;

  // Full is judged on pre-edge occupancy, so a same-cycle pop never rescues a write.
  assign full      = (count_q == DEPTH_C);
  assign push      = i_valid && !full;
  assign baud_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
      if (i_valid && full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level is computed from next state so the pin register lines up with it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign o_tx         = tx_q;
  assign o_busy       = (state_q != S_IDLE) || (count_q != '0);
  assign o_overflow   = ovf_q;
  assign o_fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_feature_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_feature_uart_tx
// Brief    : Scoreboard bench for feature_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_feature_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    i_data = 8'h00;
  logic          i_valid = 1'b0;
  logic          o_tx, o_busy, o_overflow;
  logic [CW-1:0] o_fifo_count;

  feature_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_fifo_count (o_fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         test_id = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line receiver: samples each bit mid-period and retires one scoreboard entry per frame.
  int         start_q[$];
  bit         m_active = 1'b0;
  int         m_cnt = 0;
  int         m_last_id = 0;
  logic [7:0] m_rx = 8'h00;
  always @(negedge clk) begin : p_mon
    int k;
    if (test_id != m_last_id) begin
      start_q.delete();
      m_last_id = test_id;
    end
    if (reset) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (o_tx == 1'b0) begin
        m_active = 1'b1;
        m_cnt    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      m_cnt++;
      if (m_cnt % CPB == CPB / 2) begin
        k = m_cnt / CPB;
        if (k == 0) begin
          check_eq("start_bit", 32'(o_tx), 32'd0);
        end else if (k <= 8) begin
          m_rx[k-1] = o_tx;
        end else begin
          check_eq("stop_bit", 32'(o_tx), 32'd1);
          check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check_eq("rx_byte", 32'(m_rx), 32'(exp_q.pop_front()));
          m_active = 1'b0;
        end
      end
    end
  end

  int peak = 0;
  int p_last_id = 0;
  always @(negedge clk) begin
    if (test_id != p_last_id) begin
      peak      = 0;
      p_last_id = test_id;
    end
    if (int'(o_fifo_count) > peak) peak = int'(o_fifo_count);
  end

  task automatic do_reset();
    reset   = 1'b1;
    i_valid = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit expect_tx);
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    i_data  = b;
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic idle_in();
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy && n < budget);
    check_eq({tag, "_idle"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();
    @(negedge clk);
    check_eq("rst_tx", 32'(o_tx), 32'd1);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_ovf", 32'(o_overflow), 32'd0);
    check_eq("rst_count", 32'(o_fifo_count), 32'd0);

    // Single byte with exact latency and frame length.
    test_id = 1;
    drive_byte(8'hA5, 1'b1);
    @(negedge clk);
    check_eq("lat_n_tx", 32'(o_tx), 32'd1);
    check_eq("lat_n_count", 32'(o_fifo_count), 32'd0);
    idle_in();
    @(negedge clk);
    check_eq("lat_n1_count", 32'(o_fifo_count), 32'd1);
    check_eq("lat_n1_tx", 32'(o_tx), 32'd1);
    @(negedge clk);
    check_eq("lat_n2_tx", 32'(o_tx), 32'd0);
    n = 0;
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_len", 32'(n), 32'd40);
    check_eq("single_drained", 32'(exp_q.size()), 32'd0);
    check_eq("single_ovf", 32'(o_overflow), 32'd0);
    check_eq("single_frames", 32'(start_q.size()), 32'd1);

    // Back-to-back frames with no idle gap.
    test_id = 2;
    drive_byte(8'h01, 1'b1);
    drive_byte(8'h80, 1'b1);
    drive_byte(8'hFF, 1'b1);
    idle_in();
    wait_idle(400, "b2b");
    check_eq("b2b_frames", 32'(start_q.size()), 32'd3);
    if (start_q.size() >= 3) begin
      check_eq("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'd40);
      check_eq("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'd40);
    end
    check_eq("b2b_peak", 32'(peak), 32'd2);

    // Overflow: sixth byte of a burst is dropped.
    test_id = 3;
    for (int i = 0; i < 6; i++) drive_byte(8'(8'h10 + i), i < 5);
    idle_in();
    @(negedge clk);
    check_eq("ovf_set", 32'(o_overflow), 32'd1);
    wait_idle(600, "ovf");
    check_eq("ovf_sticky", 32'(o_overflow), 32'd1);
    check_eq("ovf_peak", 32'(peak), 32'd4);
    check_eq("ovf_frames", 32'(start_q.size()), 32'd5);

    // Reset during data bit 3 aborts the frame and flushes the FIFO.
    test_id = 4;
    drive_byte(8'h3C, 1'b0);
    drive_byte(8'h77, 1'b0);
    idle_in();
    n = 0;
    while (o_tx && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_start_seen", 32'(o_tx), 32'd0);
    repeat (17) @(negedge clk);
    check_eq("mid_pre_count", 32'(o_fifo_count), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_tx", 32'(o_tx), 32'd1);
    check_eq("mid_rst_count", 32'(o_fifo_count), 32'd0);
    check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
    check_eq("mid_rst_ovf", 32'(o_overflow), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!o_tx) n++;
    end
    check_eq("mid_no_frames", 32'(n), 32'd0);
    drive_byte(8'h5A, 1'b1);
    idle_in();
    wait_idle(200, "mid_new");

    // Sparse pulses: one byte every 100 cycles.
    test_id = 5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("sparse_gap_idle", 32'(o_busy), 32'd0);
      drive_byte(8'(i * 37 + 3), 1'b1);
      idle_in();
      repeat (98) @(posedge clk);
    end
    wait_idle(200, "sparse");
    check_eq("sparse_peak", 32'(peak), 32'd1);
    check_eq("sparse_frames", 32'(start_q.size()), 32'd5);
    if (start_q.size() >= 2) check_eq("sparse_period", 32'(start_q[1] - start_q[0]), 32'd100);

    // Pointer wrap-around: paced stream, then 4-byte bursts.
    test_id = 6;
    for (int i = 0; i < 20; i++) begin
      drive_byte(8'(i * 13 + 7), 1'b1);
      idle_in();
      repeat (43) @(posedge clk);
    end
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 4; j++) drive_byte(8'(8'hC0 + b * 4 + j), 1'b1);
      idle_in();
      repeat (200) @(posedge clk);
    end
    wait_idle(400, "wrap");
    check_eq("wrap_ovf", 32'(o_overflow), 32'd0);
    check_eq("wrap_peak", 32'(peak), 32'd3);
    check_eq("wrap_frames", 32'(start_q.size()), 32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/feature_uart_tx.md
Name: feature_uart_tx

Overview:
Consumer end of the featurizer byte stream. The stream is valid-only, with no backpressure: one 8-bit feature pulses per window. This block buffers incoming feature bytes in a small FIFO and serializes them off-chip as UART 8N1 frames. It sits between the featurize stage and the board TX pin, and decouples bursty per-window pulses from the fixed serial bit rate.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit. 50 MHz / 115200 baud. Legal range is 2 or more.
- FIFO_DEPTH, 16, number of FIFO entries. Must be a power of two, 2 or more.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- i_data, input, 8, feature byte. Sampled only when i_valid=1.
- i_valid, input, 1, single-cycle write strobe. There is no ready signal; the producer never stalls.
- o_tx, output, 1, UART serial line. Idle high. Registered.
- o_busy, output, 1, high when the FSM is not in IDLE or the FIFO is non-empty.
- o_overflow, output, 1, sticky. Set when a byte is dropped because the FIFO is full.
- o_fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values:
  - o_tx=1, o_busy=0, o_overflow=0, o_fifo_count=0.
  - FSM=IDLE; bit counter and baud counter are 0.
  - FIFO is flushed.
- Reset mid-frame: the frame is aborted and o_tx is 1 in the cycle after reset is sampled. Buffered bytes are lost.
- FIFO write rule:
  - If i_valid=1 and count<FIFO_DEPTH at the clock edge, write i_data.
  - "Full" is evaluated on pre-edge occupancy. A write is dropped when count==FIFO_DEPTH, even if a pop occurs in the same cycle.
  - A dropped write sets o_overflow=1. It stays set until reset.
- Simultaneous push and pop (not full): data is written and read, and count is unchanged.
- Pointers: read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Occupancy is tracked by a separate counter.
- FSM states:
  - IDLE: o_tx=1. If count>0, pop the head byte into the shift register and go to START. Otherwise stay in IDLE.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
    - If count>0, pop the next byte and go directly to START (back-to-back, no idle gap).
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Latency: i_valid in cycle N, with the FIFO empty and the FSM in IDLE:
  - Byte is written at the end of cycle N; count=1 in cycle N+1.
  - Popped at the end of cycle N+1.
  - o_tx=0 from cycle N+2.
- o_busy is derived combinationally from registered state: (state!=IDLE) || (count!=0).

Test Plan:
- Single byte, CLKS_PER_BIT=4. Push 0xA5 once:
  - o_tx low starting 2 cycles later.
  - Bit-periods: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). Each period is 4 cycles; frame total is 40 cycles.
  - o_busy falls once the frame is complete; o_overflow=0.
- Back-to-back, CLKS_PER_BIT=4. Push 0x01, 0x80, 0xFF in consecutive cycles:
  - Three contiguous frames, 120 cycles, with no idle cycle between stop and start.
  - o_fifo_count peaks at 2.
- Overflow, FIFO_DEPTH=4. Push 0x10..0x15 in 6 consecutive cycles:
  - Byte 0x10 is popped in cycle 1 while 0x11 is written.
  - Count reaches 4 at cycle 5, so 0x15 is dropped and o_overflow=1.
  - Exactly 0x10..0x14 are transmitted. o_overflow stays 1 after the line goes idle.
- Reset mid-frame. Push 0x3C and a second byte; assert reset during DATA bit 3:
  - o_tx=1 the next cycle; count=0 and o_busy=0.
  - No further frames are emitted. A new push after reset transmits a clean frame.
- Sparse pulses. Push one byte every 100 cycles with CLKS_PER_BIT=4:
  - Each frame is separated by an idle-high gap; o_busy deasserts between frames.
  - count never exceeds 1.
- Wrap-around, FIFO_DEPTH=4. Stream 20 bytes at one byte per 45 cycles, then 4-byte bursts:
  - All bytes are received in order across multiple pointer wraps.
  - o_overflow=0.
